approx_mult_err_monitor: RTL and testbench
==========================================

Name: approx_mult_err_monitor

Overview:
- Downstream characterisation stage for the 8x8 approximate multipliers in the library.
- Consumes operand pairs and the combinational approximate product of any library 8x8 multiplier driven by the same operands.
- Computes the exact product and the error distance ED = |exact - approx|.
- Accumulates windowed error statistics (sample count, error count, ED sum, max ED with its operands) for hardware sweeps and exhaustive-space evaluation.

Parameters:
- WIN_LOG2, 16, window length = 2^WIN_LOG2 samples; 16 covers the full 8x8 operand space.
- SUM_W, 16+WIN_LOG2, err_sum width; cannot overflow because ED <= 65025 < 2^16.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; opens a new window (accepted in IDLE/DONE only).
- in_valid  in  1  operand/product sample valid.
- in_ready  out  1  high only in RUN.
- op_a  in  8  multiplier operand A.
- op_b  in  8  multiplier operand B.
- prod_approx  in  16  approximate product for op_a, op_b.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  level, high in DONE.
- sample_cnt  out  WIN_LOG2+1  samples accumulated.
- err_cnt  out  WIN_LOG2+1  samples with ED != 0.
- err_sum  out  SUM_W  sum of ED.
- err_max  out  16  maximum ED.
- max_a  out  8  op_a of first sample reaching err_max.
- max_b  out  8  op_b of first sample reaching err_max.

Behaviour:
- Reset (async assert, sync deassert handled upstream): state IDLE; all outputs, pipeline valids and internal counters 0. Reset mid-window aborts with no residue.
- FSM states and transitions:
  - IDLE: start -> clear statistics, go to RUN.
  - RUN: accept on in_valid & in_ready at a rising edge. The accept counter reaching 2^WIN_LOG2 on an accepting edge -> DRAIN.
  - DRAIN: exactly 2 cycles, then DONE.
  - DONE: statistics frozen. start -> clear statistics, go to RUN.
- start in RUN/DRAIN: ignored. in_valid outside RUN: ignored, no side effects.
- Pipeline, for a sample accepted at edge t:
  - S1 registers op_a, op_b, prod_approx and valid at t.
  - S2 registers exact = op_a*op_b (16b unsigned), ED, op_a, op_b at t+1.
  - Statistics update at t+2.
  - The final sample's update coincides with the DRAIN->DONE edge, so done rises with final values visible.
- ED is unsigned absolute difference. Both approx > exact and approx < exact are valid.
- Update per valid S2 sample:
  - sample_cnt += 1
  - err_cnt += (ED != 0)
  - err_sum += ED
  - if ED > err_max (strict): err_max, max_a, max_b <- ED, operands
  - Ties keep the earliest sample.
- Clear on start zeroes stats and pipeline valids in the same edge. The first accept is possible on the following edge.
- No backpressure inside the pipeline; throughput is 1 sample/cycle in RUN.

Decomposition:
- Package approx_mon_pkg: OP_W=8, PROD_W=16, state enum {IDLE, RUN, DRAIN, DONE}.
- Sub-module err_dist_stage: S2 registered stage taking S1 regs and producing exact product, ED, operands, valid. Enables reuse by future relative-error monitors.

Test Plan:
- Reset: rst_n low mid-stream -> every output 0, in_ready 0, busy 0, done 0.
- WIN_LOG2=2, exact inputs (3,5,15),(10,10,100),(0,255,0),(255,255,65025) back-to-back -> done 2 cycles after last accept, sample_cnt 4, err_cnt 0, err_sum 0, err_max 0.
- WIN_LOG2=2, (3,5,14),(12,12,150),(7,9,60),(15,15,225) -> err_cnt 3, err_sum 10, err_max 6, max_a 12, max_b 12.
- Tie: (12,12,150) then (2,3,0) (ED 6 each) -> max_a 12, max_b 12 retained. Gaps in in_valid -> sample_cnt counts only accepts. start pulsed in RUN -> no effect.
- rst_n pulsed low after 2 accepts -> all zero, IDLE. start then 4 samples -> correct fresh stats. start in DONE -> stats 0 next cycle, RUN.
- WIN_LOG2=16, exhaustive A,B sweep against a library 8x8 multiplier -> sample_cnt 65536; stats match the golden model.

Source files
------------

// File: rtl/approx_mon_pkg.sv
// Shared widths and FSM encoding for the approximate-multiplier error monitor.
package approx_mon_pkg;

  localparam int OP_W   = 8;
  localparam int PROD_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/approx_mult_err_monitor_err_dist_stage.sv
// Error-distance stage: exact product of the registered operands and
// |exact - approx|, registered together with the operands and valid.
module err_dist_stage
  import approx_mon_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              vld_p1,
  input  logic [OP_W-1:0]   a_p1,
  input  logic [OP_W-1:0]   b_p1,
  input  logic [PROD_W-1:0] approx_p1,
  output logic              vld_p2,
  output logic [PROD_W-1:0] ed_p2,
  output logic [OP_W-1:0]   a_p2,
  output logic [OP_W-1:0]   b_p2
);

  // Approximate products may sit on either side of the exact one.
  function automatic logic [PROD_W-1:0] abs_diff(input logic [PROD_W-1:0] x,
                                                 input logic [PROD_W-1:0] y);
    logic signed [PROD_W:0] d;
    d = $signed({1'b0, x}) - $signed({1'b0, y});
    return d[PROD_W] ? PROD_W'(-d) : d[PROD_W-1:0];
  endfunction

  logic [PROD_W-1:0] exact_c;
  assign exact_c = PROD_W'(a_p1) * PROD_W'(b_p1);

  // S1 -> S2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   vld_p2 <= 1'b0;
    else if (clr) vld_p2 <= 1'b0;
    else          vld_p2 <= vld_p1;
  end

  always_ff @(posedge clk) begin
    ed_p2 <= abs_diff(exact_c, approx_p1);
    a_p2  <= a_p1;
    b_p2  <= b_p1;
  end

endmodule

// File: rtl/approx_mult_err_monitor.sv
// Windowed error-statistics monitor for 8x8 approximate multipliers:
// accepts 2^WIN_LOG2 samples, then reports count, error count, ED sum and max ED.
module approx_mult_err_monitor
  import approx_mon_pkg::*;
#(
  parameter int WIN_LOG2 = 16,
  parameter int SUM_W    = 16 + WIN_LOG2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OP_W-1:0]     op_a,
  input  logic [OP_W-1:0]     op_b,
  input  logic [PROD_W-1:0]   prod_approx,
  output logic                busy,
  output logic                done,
  output logic [WIN_LOG2:0]   sample_cnt,
  output logic [WIN_LOG2:0]   err_cnt,
  output logic [SUM_W-1:0]    err_sum,
  output logic [PROD_W-1:0]   err_max,
  output logic [OP_W-1:0]     max_a,
  output logic [OP_W-1:0]     max_b
);

  localparam int              CNT_W = WIN_LOG2 + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(2 ** WIN_LOG2 - 1);

  state_t            state;
  logic [CNT_W-1:0]  acc_cnt;
  logic              drain_cnt;
  logic              clr;
  logic              accept;

  logic              vld_p1;
  logic [OP_W-1:0]   a_p1;
  logic [OP_W-1:0]   b_p1;
  logic [PROD_W-1:0] approx_p1;

  logic              vld_p2;
  logic [PROD_W-1:0] ed_p2;
  logic [OP_W-1:0]   a_p2;
  logic [OP_W-1:0]   b_p2;

  assign in_ready = (state == RUN);
  assign busy     = (state == RUN) || (state == DRAIN);
  assign done     = (state == DONE);
  assign clr      = start && ((state == IDLE) || (state == DONE));
  assign accept   = in_valid && (state == RUN);

  // The two drain cycles let the last accepted sample reach the statistics
  // on the same edge that enters DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc_cnt   <= '0;
      drain_cnt <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state   <= RUN;
            acc_cnt <= '0;
          end
        end
        RUN: begin
          if (accept) begin
            acc_cnt <= acc_cnt + 1'b1;
            if (acc_cnt == LAST) begin
              state     <= DRAIN;
              drain_cnt <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt) state <= DONE;
          else           drain_cnt <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // input -> S1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   vld_p1 <= 1'b0;
    else if (clr) vld_p1 <= 1'b0;
    else          vld_p1 <= accept;
  end

  always_ff @(posedge clk) begin
    a_p1      <= op_a;
    b_p1      <= op_b;
    approx_p1 <= prod_approx;
  end

  err_dist_stage u_err_dist (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .vld_p1    (vld_p1),
    .a_p1      (a_p1),
    .b_p1      (b_p1),
    .approx_p1 (approx_p1),
    .vld_p2    (vld_p2),
    .ed_p2     (ed_p2),
    .a_p2      (a_p2),
    .b_p2      (b_p2)
  );

  // S2 -> statistics; strict compare keeps the earliest sample on ties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || clr) begin
      sample_cnt <= '0;
      err_cnt    <= '0;
      err_sum    <= '0;
      err_max    <= '0;
      max_a      <= '0;
      max_b      <= '0;
    end else if (vld_p2) begin
      sample_cnt <= sample_cnt + 1'b1;
      if (ed_p2 != '0) err_cnt <= err_cnt + 1'b1;
      err_sum <= err_sum + SUM_W'(ed_p2);
      if (ed_p2 > err_max) begin
        err_max <= ed_p2;
        max_a   <= a_p2;
        max_b   <= b_p2;
      end
    end
  end

endmodule

// File: tb/tb_approx_mult_err_monitor.sv
// Scoreboard bench: a 4-sample-window monitor for directed cases and a
// 256-sample-window monitor for a swept operand grid.
`timescale 1ns/1ps
module tb_approx_mult_err_monitor;

  localparam int W0 = 2;
  localparam int W1 = 8;

  typedef struct {
    int sc;
    int ec;
    int sum;
    int mx;
    int ma;
    int mb;
  } stats_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            start0 = 1'b0, in_valid0 = 1'b0;
  logic            in_ready0, busy0, done0;
  logic [7:0]      op_a0 = '0, op_b0 = '0, max_a0, max_b0;
  logic [15:0]     prod0 = '0, err_max0;
  logic [W0:0]     sample_cnt0, err_cnt0;
  logic [16+W0-1:0] err_sum0;

  logic            start1 = 1'b0, in_valid1 = 1'b0;
  logic            in_ready1, busy1, done1;
  logic [7:0]      op_a1 = '0, op_b1 = '0, max_a1, max_b1;
  logic [15:0]     prod1 = '0, err_max1;
  logic [W1:0]     sample_cnt1, err_cnt1;
  logic [16+W1-1:0] err_sum1;

  approx_mult_err_monitor #(.WIN_LOG2(W0), .SUM_W(16 + W0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .in_valid(in_valid0),
    .in_ready(in_ready0), .op_a(op_a0), .op_b(op_b0), .prod_approx(prod0),
    .busy(busy0), .done(done0), .sample_cnt(sample_cnt0), .err_cnt(err_cnt0),
    .err_sum(err_sum0), .err_max(err_max0), .max_a(max_a0), .max_b(max_b0)
  );

  approx_mult_err_monitor #(.WIN_LOG2(W1), .SUM_W(16 + W1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .in_valid(in_valid1),
    .in_ready(in_ready1), .op_a(op_a1), .op_b(op_b1), .prod_approx(prod1),
    .busy(busy1), .done(done1), .sample_cnt(sample_cnt1), .err_cnt(err_cnt1),
    .err_sum(err_sum1), .err_max(err_max1), .max_a(max_a1), .max_b(max_b1)
  );

  int     n_cmp = 0;
  int     n_bad = 0;
  stats_t q0[$];
  stats_t q1[$];
  stats_t m0, m1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Library-style approximate multiplier: low nibble replaced by 8.
  function automatic int apx(input int a, input int b);
    int e;
    e = a * b;
    if (e == 0) return 0;
    return (e & 32'hFFF0) | 8;
  endfunction

  function automatic stats_t zero_stats();
    stats_t s;
    s.sc = 0; s.ec = 0; s.sum = 0; s.mx = 0; s.ma = 0; s.mb = 0;
    return s;
  endfunction

  function automatic stats_t upd(input stats_t s, input int a, input int b, input int p);
    int ex, ed;
    ex = a * b;
    ed = (ex > p) ? ex - p : p - ex;
    s.sc++;
    if (ed != 0) s.ec++;
    s.sum += ed;
    if (ed > s.mx) begin
      s.mx = ed; s.ma = a; s.mb = b;
    end
    return s;
  endfunction

  task automatic cmp_stats(input string tag, input int sc, input int ec, input int sum,
                           input int mx, input int ma, input int mb, input stats_t e);
    check({tag, ".sample_cnt"}, sc, e.sc);
    check({tag, ".err_cnt"},    ec, e.ec);
    check({tag, ".err_sum"},    sum, e.sum);
    check({tag, ".err_max"},    mx, e.mx);
    check({tag, ".max_a"},      ma, e.ma);
    check({tag, ".max_b"},      mb, e.mb);
  endtask

  logic done0_q = 1'b0;
  logic done1_q = 1'b0;
  always @(negedge clk) begin
    stats_t e;
    if (done0 && !done0_q) begin
      if (q0.size() == 0) check("dut0.spurious_done", 32'(done0), 32'd0);
      else begin
        e = q0.pop_front();
        cmp_stats("dut0", int'(sample_cnt0), int'(err_cnt0), int'(err_sum0),
                  int'(err_max0), int'(max_a0), int'(max_b0), e);
      end
    end
    if (done1 && !done1_q) begin
      if (q1.size() == 0) check("dut1.spurious_done", 32'(done1), 32'd0);
      else begin
        e = q1.pop_front();
        cmp_stats("dut1", int'(sample_cnt1), int'(err_cnt1), int'(err_sum1),
                  int'(err_max1), int'(max_a1), int'(max_b1), e);
      end
    end
    done0_q = done0;
    done1_q = done1;
  end

  task automatic chk_zero0(input string tag);
    check({tag, ".in_ready"},   32'(in_ready0), 0);
    check({tag, ".busy"},       32'(busy0), 0);
    check({tag, ".done"},       32'(done0), 0);
    check({tag, ".sample_cnt"}, 32'(sample_cnt0), 0);
    check({tag, ".err_cnt"},    32'(err_cnt0), 0);
    check({tag, ".err_sum"},    32'(err_sum0), 0);
    check({tag, ".err_max"},    32'(err_max0), 0);
    check({tag, ".max_a"},      32'(max_a0), 0);
    check({tag, ".max_b"},      32'(max_b0), 0);
  endtask

  // All dut0 tasks start and end at a falling edge.
  task automatic open0();
    start0    = 1'b1;
    in_valid0 = 1'b0;
    @(negedge clk);
    start0 = 1'b0;
    m0 = zero_stats();
    check("open0.in_ready", 32'(in_ready0), 1);
    check("open0.done", 32'(done0), 0);
    check("open0.cleared", 32'(sample_cnt0) + 32'(err_cnt0) + 32'(err_sum0) + 32'(err_max0), 0);
  endtask

  task automatic sample0(input int a, input int b, input int p, input bit st);
    check("sample0.in_ready", 32'(in_ready0), 1);
    in_valid0 = 1'b1;
    op_a0     = 8'(a);
    op_b0     = 8'(b);
    prod0     = 16'(p);
    start0    = st;
    m0 = upd(m0, a, b, p);
    @(negedge clk);
    start0 = 1'b0;
  endtask

  task automatic gap0(input int n);
    in_valid0 = 1'b0;
    repeat (n) begin
      op_a0 = 8'($urandom_range(255));
      op_b0 = 8'($urandom_range(255));
      prod0 = 16'($urandom_range(65535));
      @(negedge clk);
    end
  endtask

  task automatic noise0(input int n);
    in_valid0 = 1'b1;
    repeat (n) begin
      op_a0 = 8'($urandom_range(255));
      op_b0 = 8'($urandom_range(255));
      prod0 = 16'($urandom_range(65535));
      @(negedge clk);
    end
    in_valid0 = 1'b0;
  endtask

  task automatic close0();
    in_valid0 = 1'b0;
    q0.push_back(m0);
    check("drain1.busy", 32'(busy0), 1);
    check("drain1.in_ready", 32'(in_ready0), 0);
    check("drain1.done", 32'(done0), 0);
    @(negedge clk);
    check("drain2.done", 32'(done0), 0);
    @(negedge clk);
    check("final.done", 32'(done0), 1);
    check("final.busy", 32'(busy0), 0);
  endtask

  initial begin
    int a, b, k;
    repeat (3) @(negedge clk);
    chk_zero0("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero0("idle");

    open0();
    sample0(3, 5, 15, 0); sample0(10, 10, 100, 0);
    sample0(0, 255, 0, 0); sample0(255, 255, 65025, 0);
    close0();

    open0();
    sample0(3, 5, 14, 0); sample0(12, 12, 150, 0);
    sample0(7, 9, 60, 0); sample0(15, 15, 225, 0);
    close0();
    noise0(3);
    check("frozen.done", 32'(done0), 1);
    check("frozen.sample_cnt", 32'(sample_cnt0), 4);
    check("frozen.err_sum", 32'(err_sum0), 10);
    check("frozen.err_max", 32'(err_max0), 6);

    // Tie on ED 6, gaps, and start pulses while running.
    open0();
    sample0(12, 12, 150, 0); gap0(2);
    sample0(2, 3, 0, 1);     gap0(1);
    sample0(1, 1, 1, 0);
    sample0(4, 4, 20, 1);
    close0();

    // Abort mid-window with samples still in flight.
    open0();
    sample0(20, 20, 0, 0);
    sample0(9, 9, 80, 0);
    in_valid0 = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_zero0("abort");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero0("post_abort");

    open0();
    sample0(6, 7, apx(6, 7), 0); sample0(16, 1, apx(16, 1), 0);
    sample0(200, 3, apx(200, 3), 0); sample0(255, 254, 65000, 0);
    close0();

    for (int w = 0; w < 3; w++) begin
      open0();
      for (int s = 0; s < 4; s++) begin
        a = int'($urandom_range(255));
        b = int'($urandom_range(255));
        sample0(a, b, apx(a, b), 0);
        if ($urandom_range(1) == 1 && s < 3) gap0(1);
      end
      close0();
    end

    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    m1 = zero_stats();
    check("sweep.in_ready", 32'(in_ready1), 1);
    for (int i = 0; i < 256; i++) begin
      a = (i >> 4) * 17;
      b = (i & 15) * 17;
      in_valid1 = 1'b1;
      op_a1 = 8'(a);
      op_b1 = 8'(b);
      prod1 = 16'(apx(a, b));
      m1 = upd(m1, a, b, apx(a, b));
      @(negedge clk);
    end
    in_valid1 = 1'b0;
    q1.push_back(m1);
    k = 0;
    while (!done1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("sweep.done", 32'(done1), 1);
    @(negedge clk);
    check("q0.drained", 32'(q0.size()), 0);
    check("q1.drained", 32'(q1.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
